// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge: FSM states, command register layout,
// and the data value returned when the optional APB_TIMEOUT_EN watchdog forces a transfer to end.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } apb_state_e;

    localparam logic [31:0] APB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

    localparam logic [2:0] PPROT_DEFAULT    = 3'b000;
    localparam logic [2:0] PPROT_PRIVILEGED = 3'b001;
    localparam logic [2:0] PPROT_NONSECURE  = 3'b010;
    localparam logic [2:0] PPROT_INSTR      = 3'b100;

    // Widest address the command register can carry; the bridge uses the low ADDR_W bits.
    localparam int APB_CMD_ADDR_W = 64;

    typedef struct packed {
        logic                      we;
        logic [APB_CMD_ADDR_W-1:0] addr;
        logic [31:0]               wdata;
        logic [3:0]                be;
        logic [2:0]                prot;
    } apb_cmd_t;

    localparam apb_cmd_t APB_CMD_NONE = '{
        we:    1'b0,
        addr:  '0,
        wdata: 32'h0,
        be:    4'h0,
        prot:  PPROT_DEFAULT
    };

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog for the APB master bridge, built only with APB_TIMEOUT_EN.
// Counts stalled ACCESS cycles and flags when the count has reached LIMIT.
module apb_timeout_cnt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam logic [15:0] LIMIT_C = 16'(LIMIT);

    logic [15:0] cnt_q;

    // Saturate rather than wrap so a stuck slave can never alias back below the limit.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q <= 16'h0;
        end else if (inc_i && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'h1;
        end
    end

    assign expired_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding CPU request to APB4 master bridge (SETUP/ACCESS sequencing, registered response).
// Define APB_TIMEOUT_EN to bound the ACCESS phase at TIMEOUT_CYCLES stalled cycles.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int          ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        be_i,
    input  logic [2:0]        prot_i,
    output logic              ack_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [31:0]       pwdata_o,
    output logic [2:0]        pprot_o,
    output logic [3:0]        pstrb_o,
    input  logic [31:0]       prdata_i,
    input  logic              pslverr_i,
    input  logic              pready_i
);

    apb_state_e  state_q;
    apb_cmd_t    cmd_q;
    apb_cmd_t    cmd_d;
    logic        psel_q;
    logic        penable_q;
    logic        ack_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        timeout;

    // Read commands carry no write data or strobes so the bus sees APB4-legal values.
    always_comb begin
        cmd_d      = APB_CMD_NONE;
        cmd_d.we   = we_i;
        cmd_d.addr = APB_CMD_ADDR_W'(addr_i);
        cmd_d.prot = prot_i;
        if (we_i) begin
            cmd_d.wdata = wdata_i;
            cmd_d.be    = be_i;
        end
    end

`ifdef APB_TIMEOUT_EN
    apb_timeout_cnt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q == SETUP),
        .inc_i    ((state_q == ACCESS) && !pready_i),
        .expired_o(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // Command register is cleared on leaving ACCESS, which parks every bus field at zero while psel is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_q     <= APB_CMD_NONE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_i) begin
                        cmd_q   <= cmd_d;
                        psel_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready_i || timeout) begin
                        if (pready_i) begin
                            rdata_q <= cmd_q.we ? 32'h0 : prdata_i;
                            err_q   <= pslverr_i;
                        end else begin
                            rdata_q <= APB_TIMEOUT_RDATA;
                            err_q   <= 1'b1;
                        end
                        cmd_q     <= APB_CMD_NONE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        ack_q     <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack_o     = ack_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;
    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign pwrite_o  = cmd_q.we;
    assign paddr_o   = cmd_q.addr[ADDR_W-1:0];
    assign pwdata_o  = cmd_q.wdata;
    assign pprot_o   = cmd_q.prot;
    assign pstrb_o   = cmd_q.be;

    // Address bits above ADDR_W and the limit (in the default build) are intentionally unconsumed.
    logic unusedBits;
    assign unusedBits = ^{cmd_q.addr, (TIMEOUT_CYCLES == 0)};

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts single-outstanding CPU-side requests into APB4 transfers.
- Sits between the CPU/peripheral crossbar and on-chip APB peripherals and memories.
- Drives the APB SETUP/ACCESS phases and waits on pready_i.
- Returns registered read data, slave error and a one-cycle completion pulse to the requester.

Parameters:
- ADDR_W, 32, width of paddr_o and addr_i.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before forced termination (used only with APB_TIMEOUT_EN); legal range 1..65535.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- req_i  input  1  request; held high until ack_o is seen
- we_i  input  1  1=write, 0=read
- addr_i  input  ADDR_W  byte address, passed unmodified
- wdata_i  input  32  write data
- be_i  input  4  byte enables for writes
- prot_i  input  3  protection attributes
- ack_o  output  1  one-cycle completion pulse
- rdata_o  output  32  read data, valid while ack_o=1
- err_o  output  1  transfer error, valid while ack_o=1
- psel_o  output  1  APB select
- penable_o  output  1  APB enable
- pwrite_o  output  1  APB direction
- paddr_o  output  ADDR_W  APB address
- pwdata_o  output  32  APB write data
- pprot_o  output  3  APB protection
- pstrb_o  output  4  APB write strobes
- prdata_i  input  32  APB read data
- pslverr_i  input  1  APB slave error
- pready_i  input  1  APB ready

Behaviour:
- Clocking and reset:
  - Single clock clk.
  - Reset rst is synchronous and active-high.
  - While rst=1 at a posedge: state=IDLE; all outputs including rdata_o become 0 at that edge.
- FSM states (encoding in package): IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If req_i=1, latch we_i/addr_i/wdata_i/be_i/prot_i into command registers and go to SETUP.
  - Otherwise stay in IDLE.
- SETUP (exactly 1 cycle):
  - psel_o=1, penable_o=0.
  - paddr_o, pwrite_o, pprot_o, pwdata_o and pstrb_o are driven from the command registers.
  - Go to ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1; all address/control/data outputs held stable.
  - If pready_i=1: capture prdata_i into rdata_o (reads only; writes load 0) and pslverr_i into err_o, then go to DONE.
  - Otherwise stay in ACCESS indefinitely.
- DONE (exactly 1 cycle):
  - ack_o=1, psel_o=0, penable_o=0.
  - req_i is ignored in this state, so a held request is not reissued.
  - Go to IDLE.
- Outside DONE, ack_o=0; rdata_o and err_o hold their last value.
- Latency:
  - req_i seen in IDLE at cycle 0 → SETUP at 1 → ACCESS at 2 → ack_o at cycle 3 + N, where N = wait cycles (pready_i low in ACCESS).
  - Minimum back-to-back period is 4 cycles.
- Write vs read encoding:
  - Writes: pstrb_o=be_i.
  - Reads: pstrb_o=4'b0000 and pwdata_o=0 (APB4 rule).
- When psel_o=0, paddr_o, pwdata_o, pstrb_o, pwrite_o and pprot_o are driven to 0.
- be_i=0 on a write is legal; the transfer is issued unchanged.
- pslverr_i, prdata_i and pready_i are ignored outside ACCESS.
- Reset mid-operation: the transfer is abandoned, no ack_o is produced, and psel_o drops at the reset edge.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle while pready_i=0.
  - When the count reaches TIMEOUT_CYCLES with pready_i still low, go to DONE with err_o=1 and rdata_o=32'hDEAD_BEEF.
  - psel_o drops in the DONE cycle.
  - If pready_i=1 arrives in the same cycle as the limit, pready_i wins and the transfer completes normally.
- Without the macro: no counter is built, and ACCESS waits forever.

Decomposition:
- apb_pkg holds:
  - the apb_state_e enum (IDLE, SETUP, ACCESS, DONE)
  - APB_TIMEOUT_RDATA = 32'hDEAD_BEEF
  - PPROT defaults
  - an apb_cmd_t struct {we, addr, wdata, be, prot} for the command register.
- One sub-module: apb_timeout_cnt (counter plus compare, instantiated only under APB_TIMEOUT_EN).
- Everything else stays in the top module.

Test Plan:
- Zero-wait slave, write addr=0x0000_0010, wdata=0xA5A5_1234, be=4'hF:
  - psel at cycle 1, penable at cycle 2, ack at cycle 3.
  - pstrb=4'hF; slave word at 0x10 = 0xA5A5_1234.
- 5-wait slave, read back addr=0x10:
  - penable held 6 cycles; ack at cycle 8.
  - rdata_o=0xA5A5_1234, err_o=0, pstrb_o=0 throughout.
- Byte write be=4'b0100, wdata=0x00FF_0000, then read:
  - rdata_o=0xA5FF_1234.
- Slave asserts pslverr_i with pready_i on a read:
  - ack_o=1 and err_o=1 in the same cycle.
  - The next transfer has err_o=0.
- Assert rst during ACCESS with pready_i held low:
  - All outputs 0 next edge; no ack_o.
  - A new request afterwards completes normally.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready_i stuck low:
  - ack_o=1, err_o=1, rdata_o=32'hDEAD_BEEF at cycle 7.
  - Without the macro, no ack_o occurs within 1000 cycles.
